// File: rtl/score_display_mux.sv
`default_nettype none
// ============================================================================
// Module  : score_display_mux
// Purpose : Time-multiplexed 4-digit common-anode score display driver with
//           guard cycle, leading-zero blanking and winner blink.
// Rev     : 1.0  initial release
// ============================================================================
module score_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SCANS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] p1_tens,
  input  logic [3:0] p1_ones,
  input  logic [3:0] p2_tens,
  input  logic [3:0] p2_ones,
  input  logic       lz_blank,
  input  logic [1:0] winner,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              RC_W      = $clog2(REFRESH_DIV);
  localparam int              BC_W      = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(REFRESH_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BLINK_SCANS - 1);
  localparam logic [6:0]      SEG_BLANK = 7'h7F;

  logic [RC_W-1:0] rc_q, rc_d;
  logic [1:0]      idx_q, idx_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic            bphase_q, bphase_d;
  logic [3:0]      snap_p1t_q, snap_p1o_q, snap_p2t_q, snap_p2o_q;
  logic [3:0]      snap_p1t_d, snap_p1o_d, snap_p2t_d, snap_p2o_d;
  logic            snap_lz_q, snap_lz_d;
  logic [1:0]      snap_win_q, snap_win_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            rc_wrap;
  logic            scan_wrap;
  logic            guard;
  logic [3:0]      digit;
  logic            blink_hit;
  logic            lz_hit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Scan timing: idx walks 3,2,1,0 and a full scan ends on the 0->3 step.
  always_comb begin
    rc_wrap   = (rc_q == RC_LAST);
    scan_wrap = rc_wrap && (idx_q == 2'd0);
    rc_d      = rc_wrap ? '0 : rc_q + 1'b1;
    idx_d     = rc_wrap ? idx_q - 2'd1 : idx_q;
  end

  always_comb begin
    snap_p1t_d = snap_p1t_q;
    snap_p1o_d = snap_p1o_q;
    snap_p2t_d = snap_p2t_q;
    snap_p2o_d = snap_p2o_q;
    snap_lz_d  = snap_lz_q;
    snap_win_d = snap_win_q;
    bcnt_d     = bcnt_q;
    bphase_d   = bphase_q;
    if (scan_wrap) begin
      snap_p1t_d = p1_tens;
      snap_p1o_d = p1_ones;
      snap_p2t_d = p2_tens;
      snap_p2o_d = p2_ones;
      snap_lz_d  = lz_blank;
      snap_win_d = winner;
      // Blink only advances across scans whose snapshot already had a winner;
      // a winner of 00 being loaded clears the phase on this same edge.
      if ((winner == 2'b00) || (snap_win_q == 2'b00)) begin
        bcnt_d   = '0;
        bphase_d = 1'b0;
      end else if (bcnt_q == BC_LAST) begin
        bcnt_d   = '0;
        bphase_d = ~bphase_q;
      end else begin
        bcnt_d   = bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    guard = (rc_q == '0);
    case (idx_q)
      2'd3:    digit = snap_p1t_q;
      2'd2:    digit = snap_p1o_q;
      2'd1:    digit = snap_p2t_q;
      default: digit = snap_p2o_q;
    endcase
    blink_hit = bphase_q && (idx_q[1] ? snap_win_q[0] : snap_win_q[1]);
    lz_hit    = snap_lz_q && idx_q[0] && (digit == 4'd0);

    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!guard) begin
      an_d = ~(4'b0001 << idx_q);
      dp_d = (idx_q != 2'd2);
      if (blink_hit || lz_hit) seg_d = SEG_BLANK;
      else                     seg_d = seg_decode(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rc_q       <= '0;
      idx_q      <= 2'd3;
      bcnt_q     <= '0;
      bphase_q   <= 1'b0;
      snap_p1t_q <= 4'd0;
      snap_p1o_q <= 4'd0;
      snap_p2t_q <= 4'd0;
      snap_p2o_q <= 4'd0;
      snap_lz_q  <= 1'b0;
      snap_win_q <= 2'b00;
      an_q       <= 4'hF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      rc_q       <= rc_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      bphase_q   <= bphase_d;
      snap_p1t_q <= snap_p1t_d;
      snap_p1o_q <= snap_p1o_d;
      snap_p2t_q <= snap_p2t_d;
      snap_p2o_q <= snap_p2o_d;
      snap_lz_q  <= snap_lz_d;
      snap_win_q <= snap_win_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_score_display_mux
// Purpose : Scoreboard bench for score_display_mux (REFRESH_DIV=4, BLINK_SCANS=2).
// Rev     : 1.0  initial release
// ============================================================================
module tb_score_display_mux;
  localparam int D  = 4;
  localparam int BS = 2;
  localparam int P  = 4 * D;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] p1_tens = 4'd1, p1_ones = 4'd2, p2_tens = 4'd8, p2_ones = 4'd9;
  logic       lz_blank = 1'b0;
  logic [1:0] winner = 2'b00;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: edges since reset release, snapshot, blink.
  int         m_n = 0;
  logic [3:0] s_p1t = 0, s_p1o = 0, s_p2t = 0, s_p2o = 0;
  logic       s_lz = 0;
  logic [1:0] s_win = 0;
  int         m_bcnt = 0;
  logic       m_bph = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  score_display_mux #(.REFRESH_DIV(D), .BLINK_SCANS(BS)) dut (
    .clk(clk), .reset(reset),
    .p1_tens(p1_tens), .p1_ones(p1_ones), .p2_tens(p2_tens), .p2_ones(p2_ones),
    .lz_blank(lz_blank), .winner(winner),
    .an(an), .seg(seg), .dp(dp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, m_n, got, exp);
    end
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic predict();
    exp_t       e;
    int         p, slot, off;
    logic [3:0] dig;
    logic       blank;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    if (reset) begin
      m_n = 0; s_p1t = 0; s_p1o = 0; s_p2t = 0; s_p2o = 0;
      s_lz = 0; s_win = 0; m_bcnt = 0; m_bph = 0;
    end else begin
      m_n++;
      p    = (m_n - 1) % P;
      slot = 3 - p / D;
      off  = p % D;
      if (off != 0) begin
        e.an[slot] = 1'b0;
        case (slot)
          3:       dig = s_p1t;
          2:       dig = s_p1o;
          1:       dig = s_p2t;
          default: dig = s_p2o;
        endcase
        blank = m_bph && ((slot >= 2) ? s_win[0] : s_win[1]);
        if (s_lz && (slot == 3 || slot == 1) && dig == 4'd0) blank = 1'b1;
        e.seg = blank ? 7'h7F : dec7(dig);
        e.dp  = (slot == 2) ? 1'b0 : 1'b1;
      end
      if (m_n % P == 0) begin
        if (winner == 2'b00 || s_win == 2'b00) begin
          m_bcnt = 0; m_bph = 1'b0;
        end else if (m_bcnt == BS - 1) begin
          m_bcnt = 0; m_bph = ~m_bph;
        end else begin
          m_bcnt++;
        end
        s_p1t = p1_tens; s_p1o = p1_ones; s_p2t = p2_tens; s_p2o = p2_ones;
        s_lz = lz_blank; s_win = winner;
      end
    end
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("an",  32'(an),  32'(e.an));
    check("seg", 32'(seg), 32'(e.seg));
    check("dp",  32'(dp),  32'(e.dp));
  endtask

  task automatic run_to(input int target);
    while (m_n < target) step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);

    reset = 1'b0;
    step();
    check("first_guard_an", 32'(an), 32'hF);
    step();
    check("first_scan_an", 32'(an), 32'h7);
    check("first_scan_zero", 32'(seg), 32'h40);

    // Scan 1 shows 1,2,8,9 loaded at edge 16.
    run_to(18); check("dec_1", 32'(seg), 32'h79);
    run_to(20); p2_ones = 4'd12;
    run_to(22); check("dec_2", 32'(seg), 32'h24); check("dp_sep", 32'(dp), 32'h0);
    run_to(26); check("dec_8", 32'(seg), 32'h00); check("an_p2t", 32'(an), 32'hD);
    run_to(30); check("dec_9_pre_snap", 32'(seg), 32'h10);

    // Snapshot coherence: 3 loaded at edge 32, changed to 7 mid scan 2.
    run_to(31); p1_tens = 4'd3;
    run_to(34); check("coh_old", 32'(seg), 32'h30);
    run_to(38); p1_tens = 4'd7;
    run_to(46); check("dec_dash", 32'(seg), 32'h3F);
    run_to(50); check("coh_new", 32'(seg), 32'h78);

    // Leading-zero blanking, loaded at edge 64.
    run_to(63); p1_tens = 0; p1_ones = 5; p2_tens = 0; p2_ones = 0; lz_blank = 1'b1;
    run_to(66); check("lz_p1t", 32'(seg), 32'h7F); check("lz_an", 32'(an), 32'h7);
    run_to(70); check("lz_p1o", 32'(seg), 32'h12);
    run_to(74); check("lz_p2t", 32'(seg), 32'h7F);
    run_to(78); check("lz_p2o", 32'(seg), 32'h40);

    // Blink for player 2, loaded at edge 80: scans 5,6 lit, 7 blank.
    run_to(79); winner = 2'b10; p2_tens = 1; p2_ones = 1; lz_blank = 1'b0;
    run_to(90);  check("blink_s5", 32'(seg), 32'h79);
    run_to(106); check("blink_s6", 32'(seg), 32'h79);
    run_to(114); check("blink_p1_ok", 32'(seg), 32'h40);
    run_to(122); check("blink_s7_t", 32'(seg), 32'h7F);
    run_to(126); check("blink_s7_o", 32'(seg), 32'h7F); check("blink_s7_an", 32'(an), 32'hE);
    run_to(127); winner = 2'b00;
    run_to(138); check("unblink_s8", 32'(seg), 32'h79);

    // Mid-scan reset while an=1101.
    run_to(154);
    check("pre_rst_an", 32'(an), 32'hD);
    reset = 1'b1;
    step();
    check("mrst_an", 32'(an), 32'hF);
    check("mrst_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    step();
    check("mrst_guard", 32'(an), 32'hF);
    step();
    check("mrst_an0", 32'(an), 32'h7);
    check("mrst_zero", 32'(seg), 32'h40);
    run_to(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
